adder_share_arb: RTL and testbench

- Shares one instance of the team's 32-bit ripple adder (Adder_32bits: a_in, b_in, c_in, sum_o, c_o) among NUM_REQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- Each result is registered and returned on a single response channel, tagged with the requester ID.
- Sits between the datapath clients and the shared adder. The adder itself stays purely combinational.

---
 rtl/adder_arb_pkg.sv | 13 +
 rtl/Adder_32bits.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/adder_share_arb.sv | 106 ++++++++++
 tb/tb_adder_share_arb.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared parameters and FSM encoding for the shared-adder arbiter.
package adder_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/Adder_32bits.sv
// Team 32-bit ripple-carry adder; purely combinational.
module Adder_32bits (
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        c_in,
    output logic [31:0] sum_o,
    output logic        c_o
);

    logic [32:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum_o[i] = a_in[i] ^ b_in[i] ^ c[i];
        assign c[i+1]   = (a_in[i] & b_in[i]) | (c[i] & (a_in[i] ^ b_in[i]));
    end

    assign c_o = c[32];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = adder_arb_pkg::NUM_REQ,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    logic [ID_W-1:0] idx;

    // NUM_REQ is a power of two, so ID_W-bit addition wraps the search for free.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_id          = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one 32-bit adder among NUM_REQ requesters with round-robin arbitration
// and a single-entry registered response channel tagged with the requester ID.
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = adder_arb_pkg::NUM_REQ,
    parameter int WIDTH   = adder_arb_pkg::WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id
);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic               can_accept;
    logic               xfer;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .any        (gnt_any)
    );

    // rst_n gating keeps req_ready low for the whole reset interval.
    assign can_accept = rst_n & ((state == EMPTY) | (rsp_valid & rsp_ready));
    assign req_ready  = can_accept ? gnt_onehot : '0;
    assign xfer       = can_accept & gnt_any;

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_cin = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_onehot[i]) begin
                op_a   = req_a[i*WIDTH +: WIDTH];
                op_b   = req_b[i*WIDTH +: WIDTH];
                op_cin = req_cin[i];
            end
        end
    end

    Adder_32bits u_add (
        .a_in  (op_a),
        .b_in  (op_b),
        .c_in  (op_cin),
        .sum_o (add_sum),
        .c_o   (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else begin
            if (xfer) begin
                state     <= FULL;
                rr_ptr    <= gnt_id + ID_W'(1);
                rsp_valid <= 1'b1;
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
                rsp_id    <= gnt_id;
            end else begin
                case (state)
                    EMPTY: state <= EMPTY;
                    FULL: begin
                        // Drained with nothing to refill; payload left stale.
                        if (rsp_ready) begin
                            state     <= EMPTY;
                            rsp_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        rsp_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb with hand-computed expectations.
module tb_adder_share_arb;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_sum;
    logic             rsp_cout;
    logic [1:0]       rsp_id;

    int ncmp = 0;
    int nerr = 0;

    adder_share_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [31:0] s,
                           input logic co, input logic [1:0] id);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
        chk({tag, "_sum"},   64'(rsp_sum),   64'(s));
        chk({tag, "_cout"},  64'(rsp_cout),  64'(co));
        chk({tag, "_id"},    64'(rsp_id),    64'(id));
    endtask

    initial begin
        logic [N-1:0] exp_gnt;
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests present to check req_ready gating.
        @(negedge clk);
        chk_rsp("reset", 1'b0, 32'h0, 1'b0, 2'd0);
        chk("reset_ready", 64'(req_ready), 64'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from 0.
        @(negedge clk);
        set_op(0, 32'h57b451c7, 32'h9712093b, 1'b0);
        req_valid = 4'b0001;
        #1 chk("t1_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        chk_rsp("t1", 1'b1, 32'heec65b02, 1'b0, 2'd0);
        req_valid = '0;

        // Fairness after skip: ptr=1, only req3 valid.
        @(negedge clk);
        chk("t1_drain_valid", 64'(rsp_valid), 64'h0);
        chk("t1_stale_sum", 64'(rsp_sum), 64'heec65b02);
        set_op(3, 32'h1, 32'h2, 1'b0);
        req_valid = 4'b1000;
        #1 chk("fair_ready3", 64'(req_ready), 64'h8);
        @(negedge clk);
        chk_rsp("fair3", 1'b1, 32'h3, 1'b0, 2'd3);
        req_valid = 4'b1001;
        #1 chk("fair_ready0", 64'(req_ready), 64'h1);
        @(negedge clk);
        chk_rsp("fair0", 1'b1, 32'heec65b02, 1'b0, 2'd0);
        req_valid = '0;

        // Wrap with carry from requester 2.
        @(negedge clk);
        set_op(2, 32'hfffffff0, 32'h0000000f, 1'b1);
        req_valid = 4'b0100;
        #1 chk("wrap_ready", 64'(req_ready), 64'h4);
        @(negedge clk);
        chk_rsp("wrap", 1'b1, 32'h0, 1'b1, 2'd2);
        req_valid = '0;

        // Reset mid-operation while FULL.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("rst_full_valid", 64'(rsp_valid), 64'h1);
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1 chk("rst_async_valid", 64'(rsp_valid), 64'h0);
        chk("rst_async_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // All four valid continuously: expect 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'h10000000, 1'b0);
        req_valid = '1;
        #1 chk("rr_ready_first", 64'(req_ready), 64'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_rsp($sformatf("rr%0d", k), 1'b1, 32'h10000001 + 32'(k % 4), 1'b0, 2'(k % 4));
            if (k == 4) begin
                req_valid = '0;
            end else begin
                exp_gnt = '0;
                exp_gnt[(k + 1) % 4] = 1'b1;
                #1 chk($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(exp_gnt));
            end
        end

        // Backpressure with req1 held.
        @(negedge clk);
        chk("bp_empty", 64'(rsp_valid), 64'h0);
        rsp_ready = 1'b0;
        set_op(1, 32'ha0000575, 32'h00004ab4, 1'b0);
        req_valid = 4'b0010;
        #1 chk("bp_first_ready", 64'(req_ready), 64'h2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_ready%0d", k), 64'(req_ready), 64'h0);
            chk_rsp($sformatf("bp_hold%0d", k), 1'b1, 32'ha0005029, 1'b0, 2'd1);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(req_ready), 64'h2);
        @(negedge clk);
        chk_rsp("bp_refill", 1'b1, 32'ha0005029, 1'b0, 2'd1);
        req_valid = '0;
        @(negedge clk);
        chk("bp_drain_valid", 64'(rsp_valid), 64'h0);
        chk("bp_stale_id", 64'(rsp_id), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
